// File: rtl/hdlc_rx_pkg.sv
// rtl/hdlc_rx_pkg.sv - shared constants and state type for the HDLC receive deframer
package hdlc_rx_pkg;

  // Opening/closing flag as it appears in the LSB-first window
  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  // Consecutive 1s that signal an abort
  localparam int ABORT_ONES = 7;
  // Consecutive data 1s after which the transmitter inserts a 0
  localparam int STUFF_ONES = 5;

  typedef enum logic [1:0] {
    IDLE,
    FLAG,
    RECEIVING
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_pattern_detect.sv
// rtl/hdlc_rx_pattern_detect.sv - serial window with registered flag/abort decode and aligned data bit
module hdlc_rx_pattern_detect
  import hdlc_rx_pkg::*;
#(
  parameter logic [7:0] FLAG_WORD = 8'h7E
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rx,
  output logic flag_det,
  output logic abort_det,
  output logic data_bit
);

  // Newest bit enters at bit 7, so bit 0 holds the oldest (first received) bit
  logic [7:0] window;
  // Two extra stages line the outgoing data bit up with the registered detect
  // pulses: the last bit before a flag is consumed in the flag_det cycle
  logic [1:0] data_dly;
  logic       abort_run;
  logic       abort_now;

  assign abort_now = &window[7 -: ABORT_ONES];
  assign data_bit  = data_dly[1];

  // Shift the line in every cycle and register the pattern decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window    <= 8'hFF;
      data_dly  <= 2'b11;
      flag_det  <= 1'b0;
      abort_det <= 1'b0;
      abort_run <= 1'b0;
    end else begin
      window    <= {rx, window[7:1]};
      data_dly  <= {data_dly[0], window[0]};
      flag_det  <= en && (window == FLAG_WORD);
      // Report only the first cycle of a run of 1s
      abort_det <= en && abort_now && !abort_run;
      abort_run <= abort_now;
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// rtl/hdlc_rx_deframer.sv - HDLC receive deframer: zero removal, byte assembly and frame delimiting
module hdlc_rx_deframer
  import hdlc_rx_pkg::*;
#(
  parameter int         MIN_FRAME_BYTES = 4,
  parameter logic [7:0] FLAG_PATTERN    = hdlc_rx_pkg::FLAG_PATTERN
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_StartZeroDetect,
  output logic       Rx_StartFCS,
  output logic       Rx_StopFCS,
  output logic       Rx_EoF,
  output logic       Rx_FrameError
);

  localparam logic [7:0] MIN_BYTES = 8'(MIN_FRAME_BYTES);

  rx_state_t  state;
  logic       flag_det;
  logic       abort_det;
  logic       data_bit;
  logic [2:0] since_flag;
  logic [2:0] bit_cnt;
  logic [2:0] ones;
  logic [7:0] byte_cnt;
  logic [7:0] shreg;
  logic       eof_pend;
  logic       err_pend;

  logic       stuffed;
  logic       take;
  logic       byte_done;
  logic       close_err;
  logic [2:0] bit_cnt_next;
  logic [7:0] byte_cnt_next;
  logic [7:0] shreg_next;

  hdlc_rx_pattern_detect #(
    .FLAG_WORD(FLAG_PATTERN)
  ) u_detect (
    .clk      (Clk),
    .rst      (Rst),
    .en       (RxEN),
    .rx       (Rx),
    .flag_det (flag_det),
    .abort_det(abort_det),
    .data_bit (data_bit)
  );

  assign Rx_FlagDetect  = flag_det;
  assign Rx_AbortDetect = abort_det;

  // Decide whether this cycle's data bit is kept, and what counters become if so;
  // the close-error check uses the post-update counts so a byte finishing in the
  // flag cycle is counted
  always_comb begin
    stuffed       = (ones >= 3'(STUFF_ONES)) && !data_bit;
    take          = (state == RECEIVING) && RxEN && !stuffed;
    shreg_next    = {data_bit, shreg[7:1]};
    byte_done     = take && (bit_cnt == 3'd7);
    bit_cnt_next  = take ? bit_cnt + 3'd1 : bit_cnt;
    byte_cnt_next = (byte_done && (byte_cnt != 8'hFF)) ? byte_cnt + 8'd1 : byte_cnt;
    close_err     = (bit_cnt_next != 3'd0) || (byte_cnt_next < MIN_BYTES);
  end

  // Frame state machine with byte assembly and registered frame outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state              <= IDLE;
      since_flag         <= 3'd0;
      bit_cnt            <= 3'd0;
      ones               <= 3'd0;
      byte_cnt           <= 8'd0;
      shreg              <= 8'd0;
      eof_pend           <= 1'b0;
      err_pend           <= 1'b0;
      Rx_Data            <= 8'h00;
      Rx_NewByte         <= 1'b0;
      Rx_ValidFrame      <= 1'b0;
      Rx_StartZeroDetect <= 1'b0;
      Rx_StartFCS        <= 1'b0;
      Rx_StopFCS         <= 1'b0;
      Rx_EoF             <= 1'b0;
      Rx_FrameError      <= 1'b0;
    end else begin
      Rx_NewByte    <= 1'b0;
      Rx_StartFCS   <= 1'b0;
      Rx_StopFCS    <= 1'b0;
      Rx_EoF        <= eof_pend;
      Rx_FrameError <= eof_pend && err_pend;
      eof_pend      <= 1'b0;
      err_pend      <= 1'b0;

      if (take) begin
        shreg    <= shreg_next;
        bit_cnt  <= bit_cnt_next;
        byte_cnt <= byte_cnt_next;
      end
      if (byte_done) begin
        Rx_Data    <= shreg_next;
        Rx_NewByte <= 1'b1;
      end

      // Run of consecutive data 1s; a discarded stuffed 0 also clears it
      if ((state == RECEIVING) && RxEN) begin
        if (data_bit) ones <= (ones == 3'd7) ? ones : ones + 3'd1;
        else          ones <= 3'd0;
      end else begin
        ones <= 3'd0;
      end

      if (!RxEN) begin
        state <= IDLE;
        if (state == RECEIVING) begin
          Rx_ValidFrame      <= 1'b0;
          Rx_StartZeroDetect <= 1'b0;
          Rx_StopFCS         <= 1'b1;
          eof_pend           <= 1'b1;
          err_pend           <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (flag_det) begin
              state      <= FLAG;
              since_flag <= 3'd0;
            end
          end
          FLAG: begin
            if (abort_det) begin
              state <= IDLE;
            end else if (flag_det) begin
              since_flag <= 3'd0;
            end else if (since_flag == 3'd7) begin
              state              <= RECEIVING;
              bit_cnt            <= 3'd0;
              byte_cnt           <= 8'd0;
              shreg              <= 8'd0;
              Rx_ValidFrame      <= 1'b1;
              Rx_StartZeroDetect <= 1'b1;
              Rx_StartFCS        <= 1'b1;
            end else begin
              since_flag <= since_flag + 3'd1;
            end
          end
          RECEIVING: begin
            if (flag_det) begin
              // The closing flag may also open the next frame
              state              <= FLAG;
              since_flag         <= 3'd0;
              Rx_ValidFrame      <= 1'b0;
              Rx_StartZeroDetect <= 1'b0;
              Rx_StopFCS         <= 1'b1;
              eof_pend           <= 1'b1;
              err_pend           <= close_err;
            end else if (abort_det) begin
              state              <= IDLE;
              Rx_ValidFrame      <= 1'b0;
              Rx_StartZeroDetect <= 1'b0;
              Rx_StopFCS         <= 1'b1;
              eof_pend           <= 1'b1;
              err_pend           <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
